// File: rtl/shift_reg_burst.sv
// Parametrised universal shift register with single-step modes and an
// autonomous burst engine that applies N shifts/rotates with busy/done status.
module shift_reg_burst #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             D,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] par_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    output logic [WIDTH-1:0] P,
    output logic             ser_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic             fill_q;
    logic [CNT_W-1:0] cnt_q;

    logic [2:0]       sel_op;
    logic             sel_fill;
    logic [WIDTH-1:0] step_p;
    logic             step_ser;
    logic             is_shift;
    logic [CNT_W-1:0] clamp_cnt;

    // Next register value for one step of the active op (latched op during a burst)
    always_comb begin
        sel_op   = (state == BURST) ? op_q : mode_i;
        sel_fill = (state == BURST) ? fill_q : D;
        step_p   = P;
        step_ser = ser_o;
        case (sel_op)
            MODE_LOAD: step_p = par_i;
            MODE_SHL: begin
                step_p   = {P[WIDTH-2:0], sel_fill};
                step_ser = P[WIDTH-1];
            end
            MODE_SHR: begin
                step_p   = {sel_fill, P[WIDTH-1:1]};
                step_ser = P[0];
            end
            MODE_ROL: begin
                step_p   = {P[WIDTH-2:0], P[WIDTH-1]};
                step_ser = P[WIDTH-1];
            end
            MODE_ROR: begin
                step_p   = {P[0], P[WIDTH-1:1]};
                step_ser = P[0];
            end
            default: ;
        endcase
    end

    // Burst acceptance qualifiers: only shift/rotate modes start a burst; count saturates at WIDTH
    always_comb begin
        is_shift  = (mode_i == MODE_SHL) || (mode_i == MODE_SHR) ||
                    (mode_i == MODE_ROL) || (mode_i == MODE_ROR);
        clamp_cnt = (count_i > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count_i;
    end

    // Control FSM and datapath registers; all outputs registered
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state  <= IDLE;
            op_q   <= MODE_HOLD;
            fill_q <= 1'b0;
            cnt_q  <= '0;
            P      <= '0;
            ser_o  <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && is_shift) begin
                        op_q   <= mode_i;
                        fill_q <= D;
                        cnt_q  <= clamp_cnt;
                        if (clamp_cnt != '0) begin
                            busy_o <= 1'b1;
                            state  <= BURST;
                        end else begin
                            done_o <= 1'b1;
                        end
                    end else begin
                        P     <= step_p;
                        ser_o <= step_ser;
                    end
                end
                BURST: begin
                    P     <= step_p;
                    ser_o <= step_ser;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_burst.sv
// Self-checking bench for shift_reg_burst: 8-bit and 16-bit instances,
// expected burst results queued at launch and compared at done_o.
module tb_shift_reg_burst;

    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] SHL  = 3'b010;
    localparam logic [2:0] SHR  = 3'b011;
    localparam logic [2:0] ROL  = 3'b100;
    localparam logic [2:0] ROR  = 3'b101;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic        nrst;
    logic        d8, start8, ser8, busy8, done8;
    logic [2:0]  mode8;
    logic [7:0]  par8, p8;
    logic [3:0]  count8;
    logic        d16, start16, ser16, busy16, done16;
    logic [2:0]  mode16;
    logic [15:0] par16, p16;
    logic [4:0]  count16;

    shift_reg_burst #(.WIDTH(8)) u_dut8 (
        .clk(tb_clk), .nrst(nrst), .D(d8), .mode_i(mode8), .par_i(par8),
        .start_i(start8), .count_i(count8), .P(p8), .ser_o(ser8),
        .busy_o(busy8), .done_o(done8)
    );

    shift_reg_burst #(.WIDTH(16)) u_dut16 (
        .clk(tb_clk), .nrst(nrst), .D(d16), .mode_i(mode16), .par_i(par16),
        .start_i(start16), .count_i(count16), .P(p16), .ser_o(ser16),
        .busy_o(busy16), .done_o(done16)
    );

    typedef struct {
        logic [15:0] p;
        logic        ser;
        int          cycles;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Count one comparison and report a mismatch
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Closed-form result of n (clamped) shifts/rotates: {ser, p}
    function automatic logic [16:0] ref_burst(input int w, input logic [2:0] op,
                                              input logic fill, input logic [15:0] p, input int n);
        logic [31:0] pp, mask, ones, r;
        logic        s;
        int          k;
        k    = (n > w) ? w : n;
        pp   = 32'(p);
        mask = (32'd1 << w) - 32'd1;
        ones = (32'd1 << k) - 32'd1;
        r    = pp;
        s    = 1'b0;
        case (op)
            SHL: begin r = ((pp << k) | (fill ? ones : 32'd0)) & mask; s = pp[w-k]; end
            SHR: begin r = (pp >> k) | (fill ? (ones << (w - k)) : 32'd0); s = pp[k-1]; end
            ROL: begin r = ((pp << k) | (pp >> (w - k))) & mask; s = pp[w-k]; end
            ROR: begin r = ((pp >> k) | (pp << (w - k))) & mask; s = pp[k-1]; end
            default: ;
        endcase
        return {s, r[15:0]};
    endfunction

    task automatic idle8();
        mode8 = HOLD; start8 = 1'b0; d8 = 1'b0;
    endtask

    task automatic step8(input logic [2:0] m, input logic d, input logic [7:0] par);
        mode8 = m; d8 = d; par8 = par; start8 = 1'b0;
        @(negedge tb_clk);
    endtask

    task automatic pulse_reset();
        nrst = 1'b0;
        idle8();
        @(negedge tb_clk);
        @(negedge tb_clk);
        nrst = 1'b1;
    endtask

    // Launch an 8-bit burst, scramble inputs while busy, compare at done_o
    task automatic burst8(input logic [2:0] m, input logic d, input logic [3:0] cnt,
                          input logic [7:0] exp_p, input logic exp_ser, input int exp_cycles);
        exp_t e;
        int   busy_cnt;
        int   budget;
        mode8 = m; d8 = d; count8 = cnt; start8 = 1'b1;
        e.p = 16'(exp_p); e.ser = exp_ser; e.cycles = exp_cycles;
        sb_q.push_back(e);
        @(negedge tb_clk);
        idle8();
        busy_cnt = 0;
        budget   = 0;
        while (done8 !== 1'b1 && budget < 40) begin
            if (busy8 === 1'b1) begin
                busy_cnt++;
                mode8  = 3'($urandom);
                d8     = 1'($urandom);
                par8   = 8'($urandom);
                start8 = 1'($urandom);
                count8 = 4'($urandom);
            end else begin
                idle8();
            end
            budget++;
            @(negedge tb_clk);
        end
        idle8();
        check("burst8_done_seen", 32'(done8), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("burst8_p", 32'(p8), 32'(e.p[7:0]));
            check("burst8_ser", 32'(ser8), 32'(e.ser));
            check("burst8_busy_cycles", 32'(busy_cnt), 32'(e.cycles));
        end
        check("burst8_busy_low_at_done", 32'(busy8), 32'd0);
        @(negedge tb_clk);
        check("burst8_done_one_cycle", 32'(done8), 32'd0);
    endtask

    // Count busy cycles on the 16-bit instance until done_o, bounded
    task automatic wait16(output int busy_cnt);
        int budget;
        busy_cnt = 0;
        budget   = 0;
        while (done16 !== 1'b1 && budget < 40) begin
            if (busy16 === 1'b1) busy_cnt++;
            budget++;
            @(negedge tb_clk);
        end
        check("burst16_done_seen", 32'(done16), 32'd1);
    endtask

    initial begin
        logic [7:0]  bits;
        logic [7:0]  v;
        logic [2:0]  m;
        logic        d;
        int          n;
        int          bc;
        logic [16:0] r;
        exp_t        e;

        nrst = 1'b0;
        mode8 = LOAD; par8 = 8'h77; d8 = 1'b0; start8 = 1'b0; count8 = '0;
        mode16 = LOAD; par16 = 16'h7777; d16 = 1'b0; start16 = 1'b0; count16 = '0;

        // Reset dominates LOAD
        @(negedge tb_clk);
        repeat (3) begin
            @(negedge tb_clk);
            check("rst_p_held", 32'(p8), 32'h0);
        end
        nrst = 1'b1;
        check("rst_p", 32'(p8), 32'h0);
        check("rst_busy", 32'(busy8), 32'h0);
        check("rst_done", 32'(done8), 32'h0);
        check("rst_ser", 32'(ser8), 32'h0);
        idle8();
        mode16 = HOLD;
        @(negedge tb_clk);

        // Single-step SHL / SHR streams
        bits = 8'b1010_1010;
        for (int i = 0; i < 8; i++) step8(SHL, bits[7-i], 8'h00);
        check("shl_stream_p", 32'(p8), 32'hAA);
        check("shl_stream_ser", 32'(ser8), 32'h0);
        pulse_reset();
        for (int i = 0; i < 8; i++) step8(SHR, bits[7-i], 8'h00);
        check("shr_stream_p", 32'(p8), 32'h55);
        check("shr_stream_ser", 32'(ser8), 32'h0);

        // HOLD and reserved codes keep P
        pulse_reset();
        step8(HOLD, 1'b1, 8'h55);
        step8(HOLD, 1'b1, 8'h55);
        check("hold_p", 32'(p8), 32'h0);
        step8(3'b110, 1'b1, 8'h55);
        step8(3'b111, 1'b1, 8'h55);
        check("reserved_p", 32'(p8), 32'h0);

        // ROL burst of 3 from 0x81
        step8(LOAD, 1'b0, 8'h81);
        check("load_p", 32'(p8), 32'h81);
        burst8(ROL, 1'b0, 4'd3, 8'h0C, 1'b0, 3);

        // Clamped SHR burst, then zero-count burst
        step8(LOAD, 1'b0, 8'h00);
        burst8(SHR, 1'b1, 4'd12, 8'hFF, 1'b0, 8);
        burst8(SHR, 1'b0, 4'd0, 8'hFF, 1'b0, 0);

        // start with LOAD is ignored: LOAD executes, no burst
        mode8 = LOAD; par8 = 8'h3C; count8 = 4'd5; start8 = 1'b1;
        @(negedge tb_clk);
        idle8();
        check("start_load_p", 32'(p8), 32'h3C);
        check("start_load_busy", 32'(busy8), 32'h0);
        @(negedge tb_clk);
        check("start_load_done", 32'(done8), 32'h0);

        // Reset in the middle of an SHL burst
        step8(LOAD, 1'b0, 8'hF0);
        mode8 = SHL; d8 = 1'b0; count8 = 4'd8; start8 = 1'b1;
        @(negedge tb_clk);
        idle8();
        repeat (3) @(negedge tb_clk);
        check("mid_burst_p", 32'(p8), 32'h80);
        check("mid_burst_busy", 32'(busy8), 32'h1);
        nrst = 1'b0;
        @(negedge tb_clk);
        nrst = 1'b1;
        check("abort_p", 32'(p8), 32'h0);
        check("abort_busy", 32'(busy8), 32'h0);
        check("abort_done", 32'(done8), 32'h0);
        @(negedge tb_clk);
        check("abort_stays_idle", 32'(busy8), 32'h0);
        burst8(SHL, 1'b1, 4'd2, 8'h03, 1'b0, 2);

        // Randomised bursts against the closed-form model
        for (int i = 0; i < 6; i++) begin
            v = 8'($urandom);
            m = 3'(2 + $urandom_range(0, 3));
            d = 1'($urandom);
            n = $urandom_range(1, 10);
            step8(LOAD, 1'b0, v);
            r = ref_burst(8, m, d, 16'(v), n);
            burst8(m, d, 4'(n), r[7:0], r[16], (n > 8) ? 8 : n);
        end

        // 16-bit instance: ROR by 1, then back-to-back ROL by 2 in the done cycle
        mode16 = LOAD; par16 = 16'h8001;
        @(negedge tb_clk);
        check("w16_load_p", 32'(p16), 32'h8001);
        mode16 = ROR; d16 = 1'b0; count16 = 5'd1; start16 = 1'b1;
        e.p = 16'hC000; e.ser = 1'b1; e.cycles = 1;
        sb_q.push_back(e);
        @(negedge tb_clk);
        mode16 = HOLD; start16 = 1'b0;
        wait16(bc);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("w16_ror_p", 32'(p16), 32'(e.p));
            check("w16_ror_ser", 32'(ser16), 32'(e.ser));
            check("w16_ror_cycles", 32'(bc), 32'(e.cycles));
        end
        r = ref_burst(16, ROL, 1'b0, 16'hC000, 2);
        mode16 = ROL; d16 = 1'b0; count16 = 5'd2; start16 = 1'b1;
        e.p = 16'h0003; e.ser = 1'b1; e.cycles = 2;
        sb_q.push_back(e);
        @(negedge tb_clk);
        mode16 = HOLD; start16 = 1'b0;
        check("w16_b2b_accept", 32'(busy16), 32'h1);
        check("w16_b2b_done_low", 32'(done16), 32'h0);
        wait16(bc);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("w16_rol_p", 32'(p16), 32'(e.p));
            check("w16_rol_model_p", 32'(p16), 32'(r[15:0]));
            check("w16_rol_ser", 32'(ser16), 32'(e.ser));
            check("w16_rol_cycles", 32'(bc), 32'(e.cycles));
        end
        @(negedge tb_clk);
        check("w16_done_one_cycle", 32'(done16), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_burst.md
Name: shift_reg_burst

Overview:
Parametrised universal shift register, successor to the fixed 8-bit shift_reg. Adds WIDTH generalisation, rotate modes, a registered serial output and a burst engine that performs N shifts or rotates autonomously with busy/done status. Sits between serial links and parallel datapaths as a SIPO/PISO/barrel-style staging register.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CNT_W, $clog2(WIDTH+1), width of the burst count (derived; not overridden)

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  synchronous active-low reset
D  input  1  serial fill bit
mode_i  input  3  operation select (see Behaviour)
par_i  input  WIDTH  parallel load data
start_i  input  1  burst request, sampled with mode_i/D/count_i
count_i  input  CNT_W  burst shift count
P  output  WIDTH  parallel register contents
ser_o  output  1  last bit shifted/rotated out (registered)
busy_o  output  1  burst in progress
done_o  output  1  one-cycle burst completion pulse

Behaviour:
- Reset is synchronous: on a rising clk edge with nrst=0, P=0, ser_o=0, busy_o=0, done_o=0, burst counter=0, FSM=IDLE. Reset overrides everything, including an active burst. All outputs are registered.
- mode_i encoding:
  - 000 HOLD
  - 001 LOAD (P<=par_i)
  - 010 SHL (P<={P[WIDTH-2:0],D}, ser_o<=P[WIDTH-1])
  - 011 SHR (P<={D,P[WIDTH-1:1]}, ser_o<=P[0])
  - 100 ROL (P<={P[WIDTH-2:0],P[WIDTH-1]}, ser_o<=P[WIDTH-1])
  - 101 ROR (P<={P[0],P[WIDTH-1:1]}, ser_o<=P[0])
  - 110/111 reserved, treated as HOLD.
  - ser_o holds its value on HOLD/LOAD.
- FSM states IDLE and BURST.
- IDLE, start_i=0: mode_i executes each edge (single-step). done_o=0.
- IDLE, start_i=1:
  - If mode_i is SHL/SHR/ROL/ROR, the accepting edge latches the op and D (the fill bit) and loads the counter with min(count_i, WIDTH). P is not modified on this edge.
  - If the clamped count is >0, go to BURST with busy_o=1.
  - If the count is 0, stay IDLE and pulse done_o=1 for the next cycle.
  - start_i with HOLD/LOAD/reserved: start is ignored and the mode executes normally.
- BURST: each edge applies the latched op with the latched fill bit and decrements the counter.
  - On the edge where the counter goes 1->0: the final shift occurs, busy_o<=0, done_o<=1, FSM<=IDLE.
  - N shifts occupy exactly N cycles of busy_o=1, and done_o is high in the cycle after the N-th shift.
  - mode_i, start_i, D and par_i are ignored while busy_o=1.
- done_o is high for exactly one cycle, then 0. A start_i presented in the done_o cycle is accepted (back-to-back bursts).
- Clamp rule: count_i > WIDTH saturates to WIDTH. A rotate by WIDTH returns the original P. A shift by WIDTH fills P entirely with the fill bit.

Test Plan:
- Reset with mode_i=001, par_i=0x77 held: P stays 0x00 across edges while nrst=0. After release at negedge, P=0x00, busy_o=0, done_o=0.
- Single-step, WIDTH=8: stream 1,0,1,0,1,0,1,0 under SHL gives P=0xAA. The same stream under SHR from reset gives P=0x55. HOLD with par_i=0x55 keeps P=0x00.
- LOAD 0x81, then burst ROL with count_i=3: busy_o high exactly 3 cycles, P=0x0C, ser_o=0, done_o high for 1 cycle. Inputs changed during busy have no effect.
- From P=0x00, burst SHR with D=1 and count_i=12 (clamped to 8): P=0xFF after 8 busy cycles. Then a burst with count_i=0 gives done_o=1 next cycle, busy_o never asserts, P unchanged.
- LOAD 0xF0, start SHL burst with count 8, assert nrst=0 after 3 shifts: next edge P=0x00, busy_o=0, done_o=0, FSM IDLE. A subsequent start works normally.
- WIDTH=16: LOAD 0x8001, burst ROR with count 1 gives P=0xC000, ser_o=1. A back-to-back start in the done cycle is accepted.
